// File: rtl/gstmcu_pkg.sv
// gstmcu_pkg: shared GSTMCU video constants and the vidfetch FSM state type
package gstmcu_pkg;
  localparam int VID_AW = 21;
  typedef enum logic [1:0] {
    VF_IDLE   = 2'd0,
    VF_REQ    = 2'd1,
    VF_SETTLE = 2'd2,
    VF_DRAIN  = 2'd3
  } vf_state_t;
endpackage

// File: rtl/vidfetch_fifo.sv
// vidfetch_fifo: 16-bit word FIFO (flush_i clears all, wr_i/wdata_i push, pop_i pops, dout_o/dvalid_o/level_o/underrun_o status)
module vidfetch_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk32,
  input  logic          porb,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic [15:0]   wdata_i,
  input  logic          pop_i,
  output logic [15:0]   dout_o,
  output logic          dvalid_o,
  output logic [LW-1:0] level_o,
  output logic          underrun_o
);
  localparam int PW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q, level_d;
  logic          dvalid_q, underrun_q, do_wr, do_rd;
  assign do_wr   = wr_i && !flush_i;
  assign do_rd   = pop_i && !flush_i && level_q != '0;
  assign level_d = flush_i ? '0 : level_q + LW'(do_wr) - LW'(do_rd);
  always_ff @(posedge clk32 or negedge porb)
    if (!porb) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      dvalid_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wp_q       <= flush_i ? '0 : wp_q + PW'(do_wr);
      rp_q       <= flush_i ? '0 : rp_q + PW'(do_rd);
      level_q    <= level_d;
      dvalid_q   <= level_d != '0;
      underrun_q <= !flush_i && (underrun_q || (pop_i && level_q == '0));
    end
  always_ff @(posedge clk32)
    if (do_wr) mem[wp_q] <= wdata_i;
  assign dout_o     = mem[rp_q];
  assign dvalid_o   = dvalid_q;
  assign level_o    = level_q;
  assign underrun_o = underrun_q;
endmodule

// File: rtl/vidfetch.sv
// vidfetch: video word fetch engine (vid in, vinc strobe out, ram_req/ram_addr/ram_ack/ram_data RAM port, load/dout/dvalid/level/underrun FIFO side)
module vidfetch
  import gstmcu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic              clk32,
  input  logic              porb,
  input  logic              de,
  input  logic              vsync,
  input  logic [VID_AW-1:0] vid,
  output logic              vinc,
  output logic              ram_req,
  output logic [VID_AW-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic [15:0]       ram_data,
  input  logic              load,
  output logic [15:0]       dout,
  output logic              dvalid,
  output logic [LW-1:0]     level,
  output logic              underrun
);
  vf_state_t         state_q, state_d;
  logic              ram_req_q, ram_req_d, vinc_q, vinc_d, wr;
  logic [VID_AW-1:0] ram_addr_q, ram_addr_d;
  always_comb begin
    state_d    = state_q;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    vinc_d     = 1'b0;
    wr         = 1'b0;
    unique case (state_q)
      VF_IDLE:
        if (de && level < LW'(DEPTH) && !vsync) begin
          state_d    = VF_REQ;
          ram_req_d  = 1'b1;
          ram_addr_d = vid;
        end
      VF_REQ:
        if (ram_ack) begin
          ram_req_d = 1'b0;
          wr        = !vsync;
          vinc_d    = !vsync;
          state_d   = vsync ? VF_IDLE : VF_SETTLE;
        end else if (vsync) state_d = VF_DRAIN;
      // the vinc cycle is spent here too, then one cycle for vid to update
      VF_SETTLE: state_d = vinc_q ? VF_SETTLE : VF_IDLE;
      VF_DRAIN:
        if (ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = VF_IDLE;
        end
      default: state_d = VF_IDLE;
    endcase
  end
  always_ff @(posedge clk32 or negedge porb)
    if (!porb) begin
      state_q    <= VF_IDLE;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      vinc_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_req_q  <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      vinc_q     <= vinc_d;
    end
  assign ram_req  = ram_req_q;
  assign ram_addr = ram_addr_q;
  assign vinc     = vinc_q;
  vidfetch_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk32      (clk32),
    .porb       (porb),
    .flush_i    (vsync),
    .wr_i       (wr),
    .wdata_i    (ram_data),
    .pop_i      (load),
    .dout_o     (dout),
    .dvalid_o   (dvalid),
    .level_o    (level),
    .underrun_o (underrun)
  );
endmodule

// File: tb/tb_vidfetch.sv
// tb_vidfetch: randomized self-checking bench for vidfetch against a queue-based reference model
module tb_vidfetch;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  logic clk32, porb, de, vsync, vinc, ram_req, ram_ack, load, dvalid, underrun;
  logic [20:0] vid, ram_addr;
  logic [15:0] ram_data, dout;
  logic [LW-1:0] level;
  int total = 0, bad = 0, cyc = 0, cnt = 0, ack_dly = 2, nvinc = 0;
  logic m_under = 0, tainted = 0, load_on_ack = 0, hit = 0;
  logic [15:0] key;
  logic [15:0] q[$];
  logic [20:0] issued[$];
  int rise_cyc[$];

  vidfetch #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk32(clk32), .porb(porb), .de(de), .vsync(vsync), .vid(vid), .vinc(vinc),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_ack(ram_ack), .ram_data(ram_data),
    .load(load), .dout(dout), .dvalid(dvalid), .level(level), .underrun(underrun)
  );

  initial clk32 = 0;
  always #5 clk32 = ~clk32;

  function automatic logic [15:0] word(input logic [20:0] a);
    return a[15:0] ^ {a[20:16], a[10:0]} ^ key;
  endfunction

  task automatic model_reset();
    q.delete();
    m_under = 0;
    tainted = 0;
    cnt = 0;
    ram_ack = 0;
  endtask

  task automatic step();
    logic req_p, ack_p, vs_p, ld_p, de_p, vinc_p, exp_vinc;
    logic [LW-1:0] lvl_p;
    logic [20:0] vid_p, addr_p;
    req_p = ram_req; ack_p = ram_ack; vs_p = vsync; ld_p = load; de_p = de;
    vinc_p = vinc; lvl_p = level; vid_p = vid; addr_p = ram_addr;
    @(posedge clk32);
    #1;
    cyc++;
    if (!porb) return;
    exp_vinc = 0;
    if (ld_p && !vs_p) begin
      if (q.size() == 0) m_under = 1;
      else void'(q.pop_front());
    end
    if (req_p && ack_p) begin
      if (!vs_p && !tainted) begin
        q.push_back(word(addr_p));
        exp_vinc = 1;
      end
      tainted = 0;
    end
    if (vs_p) begin
      q.delete();
      m_under = 0;
      if (req_p && !ack_p) tainted = 1;
    end
    total++;
    if (vinc !== exp_vinc) begin bad++; $display("FAIL vinc cyc=%0d got=%b exp=%b", cyc, vinc, exp_vinc); end
    if (vinc) nvinc++;
    if (req_p) begin
      total++;
      if (ram_req !== !ack_p) begin bad++; $display("FAIL req_hold cyc=%0d got=%b exp=%b", cyc, ram_req, !ack_p); end
      else if (ram_req && ram_addr !== addr_p) begin bad++; $display("FAIL addr_hold cyc=%0d got=%h exp=%h", cyc, ram_addr, addr_p); end
    end else if (ram_req) begin
      issued.push_back(ram_addr);
      rise_cyc.push_back(cyc);
      total++;
      if (!(de_p && !vs_p && lvl_p < LW'(DEPTH)) || ram_addr !== vid_p) begin
        bad++;
        $display("FAIL req_start cyc=%0d addr=%h vid=%h de=%b vs=%b lvl=%0d", cyc, ram_addr, vid_p, de_p, vs_p, lvl_p);
      end
    end
    total++;
    if (level !== LW'(q.size())) begin bad++; $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, q.size()); end
    total++;
    if (dvalid !== (q.size() != 0)) begin bad++; $display("FAIL dvalid cyc=%0d got=%b exp=%b", cyc, dvalid, q.size() != 0); end
    total++;
    if (underrun !== m_under) begin bad++; $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, m_under); end
    if (q.size() != 0) begin
      total++;
      if (dout !== q[0]) begin bad++; $display("FAIL dout cyc=%0d got=%h exp=%h", cyc, dout, q[0]); end
    end
    if (vinc_p) vid = vid + 21'd1;
    if (ram_ack) ram_ack = 0;
    else if (ram_req) begin
      if (cnt >= ack_dly) begin
        ram_ack = 1;
        ram_data = word(ram_addr);
        cnt = 0;
        if (load_on_ack && level == LW'(2)) begin load = 1; load_on_ack = 0; hit = 1; end
      end else begin
        cnt++;
        ram_data = 16'($urandom);
      end
    end else ram_data = 16'($urandom);
  endtask

  task automatic flush_idle();
    de = 0; load = 0; vsync = 1;
    step();
    vsync = 0;
    for (int i = 0; i < 20 && ram_req; i++) step();
    vsync = 1;
    step();
    vsync = 0;
    step();
    total++;
    if (ram_req !== 0 || level !== 0) begin bad++; $display("FAIL flush_idle req=%b level=%0d exp 0/0", ram_req, level); end
  endtask

  task automatic test_reset();
    porb = 0; de = 0; vsync = 0; vid = 21'h01000; ram_ack = 0; ram_data = 0; load = 0;
    repeat (3) step();
    total++;
    if ({ram_req, vinc, dvalid, underrun} !== 4'b0 || ram_addr !== 0 || level !== 0) begin
      bad++;
      $display("FAIL reset_vals req=%b addr=%h vinc=%b dvalid=%b level=%0d under=%b exp all 0", ram_req, ram_addr, vinc, dvalid, level, underrun);
    end
    porb = 1;
    model_reset();
    step();
  endtask

  task automatic test_steady_fill();
    issued.delete();
    nvinc = 0; vid = 21'h01000; ack_dly = 2; de = 1;
    for (int i = 0; i < 80 && !(level == LW'(DEPTH) && !ram_req); i++) step();
    repeat (10) begin
      step();
      total++;
      if (ram_req !== 0) begin bad++; $display("FAIL full_no_req got=%b exp=0", ram_req); end
    end
    total++;
    if (issued.size() != 4) begin bad++; $display("FAIL fill_count got=%0d exp=4", issued.size()); end
    for (int i = 0; i < issued.size() && i < 4; i++) begin
      total++;
      if (issued[i] !== 21'h01000 + 21'(i)) begin bad++; $display("FAIL fill_addr%0d got=%h exp=%h", i, issued[i], 21'h01000 + 21'(i)); end
    end
    total++;
    if (nvinc != 4) begin bad++; $display("FAIL fill_vinc got=%0d exp=4", nvinc); end
  endtask

  task automatic test_pop_refill();
    total++;
    if (dout !== word(21'h01000)) begin bad++; $display("FAIL pop_a0 got=%h exp=%h", dout, word(21'h01000)); end
    load = 1;
    step();
    load = 0;
    total++;
    if (dout !== word(21'h01001) || level !== 3) begin
      bad++; $display("FAIL pop_a1 dout=%h level=%0d exp %h/3", dout, level, word(21'h01001));
    end
    for (int i = 0; i < 2 && !ram_req; i++) step();
    total++;
    if (ram_req !== 1 || ram_addr !== 21'h01004) begin bad++; $display("FAIL refill req=%b addr=%h exp 1/01004", ram_req, ram_addr); end
  endtask

  task automatic test_simultaneous();
    flush_idle();
    de = 1; ack_dly = 1; hit = 0; load_on_ack = 1;
    for (int i = 0; i < 60 && !hit; i++) step();
    total++;
    if (!hit) begin bad++; $display("FAIL simul_setup got=0 exp=1"); end
    step();
    load = 0; load_on_ack = 0; de = 0;
    total++;
    if (level !== 2) begin bad++; $display("FAIL simul_level got=%0d exp=2", level); end
    load = 1;
    for (int i = 0; i < 12 && (level != 0 || ram_req); i++) step();
    load = 0;
    step();
  endtask

  task automatic test_underrun();
    flush_idle();
    load = 1;
    step();
    load = 0;
    total++;
    if (underrun !== 1 || level !== 0) begin bad++; $display("FAIL underrun_set under=%b level=%0d exp 1/0", underrun, level); end
    vsync = 1;
    step();
    vsync = 0;
    total++;
    if (underrun !== 0) begin bad++; $display("FAIL underrun_clr got=%b exp=0", underrun); end
  endtask

  task automatic test_flush_in_flight();
    int nv0;
    flush_idle();
    de = 1; ack_dly = 1;
    for (int i = 0; i < 40 && level < 2; i++) step();
    ack_dly = 4;
    for (int i = 0; i < 10 && !(ram_req && !ram_ack); i++) step();
    vsync = 1; de = 0; nv0 = nvinc;
    step();
    vsync = 0;
    total++;
    if (level !== 0 || ram_req !== 1) begin bad++; $display("FAIL fif_flush level=%0d req=%b exp 0/1", level, ram_req); end
    for (int i = 0; i < 20 && ram_req; i++) step();
    repeat (3) step();
    total++;
    if (nvinc != nv0 || level !== 0 || ram_req !== 0) begin
      bad++; $display("FAIL fif_discard vinc=%0d level=%0d req=%b exp %0d/0/0", nvinc - nv0, level, ram_req, 0);
    end
  endtask

  task automatic test_back_to_back();
    flush_idle();
    rise_cyc.delete();
    ack_dly = 0; de = 1; load = 1;
    repeat (40) step();
    load = 0; de = 0;
    total++;
    if (rise_cyc.size() < 6) begin bad++; $display("FAIL b2b_count got=%0d exp>=6", rise_cyc.size()); end
    for (int i = 1; i < rise_cyc.size(); i++) begin
      total++;
      if (rise_cyc[i] - rise_cyc[i-1] != 4) begin bad++; $display("FAIL b2b_period got=%0d exp=4", rise_cyc[i] - rise_cyc[i-1]); end
    end
  endtask

  task automatic test_random();
    flush_idle();
    repeat (3000) begin
      de = ($urandom % 4) != 0;
      load = ($urandom % 3) == 0;
      vsync = ($urandom % 60) == 0;
      ack_dly = int'($urandom % 4);
      step();
    end
    de = 0; load = 0; vsync = 0;
  endtask

  task automatic test_reset_midop();
    flush_idle();
    de = 1; ack_dly = 1;
    for (int i = 0; i < 60 && !(level == LW'(DEPTH) && !ram_req); i++) step();
    ack_dly = 30;
    load = 1;
    step();
    load = 0;
    for (int i = 0; i < 5 && !ram_req; i++) step();
    total++;
    if (level !== 3 || ram_req !== 1) begin bad++; $display("FAIL midop_setup level=%0d req=%b exp 3/1", level, ram_req); end
    #2 porb = 0;
    #1;
    total++;
    if ({ram_req, vinc, dvalid, underrun} !== 4'b0 || ram_addr !== 0 || level !== 0) begin
      bad++;
      $display("FAIL midop_reset req=%b addr=%h vinc=%b dvalid=%b level=%0d under=%b exp all 0", ram_req, ram_addr, vinc, dvalid, level, underrun);
    end
    de = 0;
    repeat (2) step();
    porb = 1;
    model_reset();
    step();
  endtask

  initial begin
    key = 16'($urandom);
    test_reset();
    test_steady_fill();
    test_pop_refill();
    test_simultaneous();
    test_underrun();
    test_flush_in_flight();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
